// File: rtl/lcd_hd44780_responder_pkg.sv
// Shared definitions for the HD44780 4-bit bus responder: nibble-phase states,
// LCD command constants and the command classifier used by the decoder.
package lcd_hd44780_responder_pkg;

    typedef enum logic [1:0] {
        ST_8BIT = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } lcdState_t;

    typedef enum logic [2:0] {
        CMD_NONE     = 3'd0,
        CMD_SETDDRAM = 3'd1,
        CMD_CLEAR    = 3'd2,
        CMD_HOME     = 3'd3,
        CMD_ENTRY    = 3'd4
    } lcdCmd_t;

    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h04;
    localparam logic [7:0] LCD_CMD_SETDDRAM = 8'h80;

    // High nibble of the function-set command that selects the 4-bit interface
    localparam logic [3:0] NIBBLE_FUNC_4BIT = 4'h2;

    // Priority order matters: set-DDRAM wins over everything, clear over home
    function automatic lcdCmd_t decodeCommand(input logic [7:0] b);
        lcdCmd_t cmd;
        cmd = CMD_NONE;
        if ((b & LCD_CMD_SETDDRAM) != 8'h00)
            cmd = CMD_SETDDRAM;
        else if (b == LCD_CMD_CLEAR)
            cmd = CMD_CLEAR;
        else if (b[7:1] == LCD_CMD_HOME[7:1])
            cmd = CMD_HOME;
        else if (b[7:2] == LCD_CMD_ENTRY[7:2])
            cmd = CMD_ENTRY;
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// HD44780 4-bit bus as seen from the controller (master) and the display (slave).
interface lcd_hd44780_responder_if;
    logic [3:0] lcd;
    logic       enable;
    logic       registerSelect;
    logic       readWrite;

    modport master (
        output lcd,
        output enable,
        output registerSelect,
        output readWrite
    );

    modport slave (
        input lcd,
        input enable,
        input registerSelect,
        input readWrite
    );
endinterface

// File: rtl/lcd_hd44780_responder_busy_timer.sv
// Busy down-counter: reloads on every completed byte, counts to zero, busy while non-zero.
module lcd_hd44780_responder_busy_timer #(
    parameter int CNT_W = 17
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    output logic             busy
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset)
            count <= '0;
        else if (load)
            count <= loadValue;
        else if (count != '0)
            count <= count - CNT_W'(1);
    end

    assign busy = (count != '0);

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Device side of the HD44780 4-bit bus: nibble assembly, command decode,
// DDRAM address tracking and busy-time enforcement.
module lcd_hd44780_responder
    import lcd_hd44780_responder_pkg::*;
#(
    parameter int BUSY_CYCLES      = 2000,
    parameter int LONG_BUSY_CYCLES = 82000,
    parameter int CNT_W            = 17
) (
    input  logic                    Clock,
    input  logic                    Reset,
    lcd_hd44780_responder_if.slave  bus,
    output logic                    oByteValid,
    output logic [7:0]              oByte,
    output logic                    oIsData,
    output logic                    oCharValid,
    output logic [6:0]              oCharAddr,
    output logic [6:0]              oCursorAddr,
    output logic                    oFourBitMode,
    output logic                    oBusy,
    output logic                    oTimingError
);

    function automatic logic [6:0] stepAddr(input logic [6:0] a, input logic inc);
        return inc ? a + 7'd1 : a - 7'd1;
    endfunction

    lcdState_t  state, stateNext;
    logic [3:0] hiNibble, hiNibbleNext;
    logic       hiRs, hiRsNext;
    logic [6:0] addr, addrNext;
    logic       entryInc, entryIncNext;

    logic       enable_p1;
    logic       fall_p0;
    logic       emit_p0;
    logic [7:0] emitByte_p0;
    logic       emitRs_p0;
    logic       longLoad_p0;
    lcdCmd_t    cmd_p0;

    logic       byteVld_p1;
    logic [7:0] byte_p1;
    logic       isData_p1;
    logic       charVld_p1;
    logic [6:0] charAddr_p1;
    logic       timingError;
    logic       busy;

    // ---- p0: E falling-edge detect; read cycles never count as a strobe
    always_ff @(posedge Clock) begin
        if (Reset)
            enable_p1 <= 1'b0;
        else
            enable_p1 <= bus.enable;
    end

    assign fall_p0 = enable_p1 & ~bus.enable & ~bus.readWrite;

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= ST_8BIT;
        else
            state <= stateNext;
    end

    // Pending high nibble needs no reset: the state reset makes it unreachable
    always_ff @(posedge Clock) begin
        hiNibble <= hiNibbleNext;
        hiRs     <= hiRsNext;
    end

    always_comb begin
        stateNext    = state;
        hiNibbleNext = hiNibble;
        hiRsNext     = hiRs;
        emit_p0      = 1'b0;
        emitByte_p0  = 8'h00;
        emitRs_p0    = 1'b0;
        if (fall_p0) begin
            case (state)
                ST_8BIT: begin
                    emit_p0     = 1'b1;
                    emitByte_p0 = {bus.lcd, 4'h0};
                    emitRs_p0   = bus.registerSelect;
                    if (bus.lcd == NIBBLE_FUNC_4BIT && !bus.registerSelect)
                        stateNext = ST_HI;
                end
                ST_HI: begin
                    hiNibbleNext = bus.lcd;
                    hiRsNext     = bus.registerSelect;
                    stateNext    = ST_LO;
                end
                ST_LO: begin
                    emit_p0     = 1'b1;
                    emitByte_p0 = {hiNibble, bus.lcd};
                    emitRs_p0   = hiRs;
                    stateNext   = ST_HI;
                end
                default: stateNext = ST_8BIT;
            endcase
        end
    end

    // Command/data effect on the address counter and entry mode
    always_comb begin
        addrNext     = addr;
        entryIncNext = entryInc;
        longLoad_p0  = 1'b0;
        cmd_p0       = decodeCommand(emitByte_p0);
        if (emit_p0) begin
            if (emitRs_p0) begin
                addrNext = stepAddr(addr, entryInc);
            end else begin
                case (cmd_p0)
                    CMD_SETDDRAM: addrNext = emitByte_p0[6:0];
                    CMD_CLEAR: begin
                        addrNext     = 7'd0;
                        entryIncNext = 1'b1;
                        longLoad_p0  = 1'b1;
                    end
                    CMD_HOME: begin
                        addrNext    = 7'd0;
                        longLoad_p0 = 1'b1;
                    end
                    CMD_ENTRY: entryIncNext = emitByte_p0[1];
                    default: ;
                endcase
            end
        end
    end

    // ---- p1: registered byte/char pulses, address counter and sticky error
    always_ff @(posedge Clock) begin
        if (Reset) begin
            addr        <= 7'd0;
            entryInc    <= 1'b1;
            byteVld_p1  <= 1'b0;
            byte_p1     <= 8'h00;
            isData_p1   <= 1'b0;
            charVld_p1  <= 1'b0;
            charAddr_p1 <= 7'd0;
            timingError <= 1'b0;
        end else begin
            addr       <= addrNext;
            entryInc   <= entryIncNext;
            byteVld_p1 <= emit_p0;
            charVld_p1 <= emit_p0 & emitRs_p0;
            if (emit_p0) begin
                byte_p1   <= emitByte_p0;
                isData_p1 <= emitRs_p0;
            end
            if (emit_p0 && emitRs_p0)
                charAddr_p1 <= addr;
            if (fall_p0 && busy)
                timingError <= 1'b1;
        end
    end

    lcd_hd44780_responder_busy_timer #(
        .CNT_W(CNT_W)
    ) uBusyTimer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (emit_p0),
        .loadValue(longLoad_p0 ? CNT_W'(LONG_BUSY_CYCLES) : CNT_W'(BUSY_CYCLES)),
        .busy     (busy)
    );

    assign oByteValid   = byteVld_p1;
    assign oByte        = byte_p1;
    assign oIsData      = isData_p1;
    assign oCharValid   = charVld_p1;
    assign oCharAddr    = charAddr_p1;
    assign oCursorAddr  = addr;
    assign oFourBitMode = (state != ST_8BIT);
    assign oBusy        = busy;
    assign oTimingError = timingError;

endmodule
